sp_rx_buffer: RTL and testbench
===============================

// Module: sp_rx_buffer
// PURPOSE
//   Receive-side elastic buffer directly downstream of the serial-to-parallel stage. Accepts its 9-bit
//   {valid,data} words on clk2f and drops idle/invalid words. Stores valid bytes in a small synchronous
//   FIFO that the next consumer drains with a pop handshake. Reports fill level, overflow and a
//   link-state machine.
// PARAMETERS
//   DEPTH      8  FIFO entries; power of two, >=4
//   AF_THRESH  6  almost_full asserted when count >= AF_THRESH
//   AE_THRESH  2  almost_empty asserted when count <= AE_THRESH
// PORTS
//   clk2f         in   1  word clock, same domain as the serial-to-parallel output
//   reset_L       in   1  asynchronous, active-low reset
//   in_word       in   9  [8]=valid, [7:0]=data, from the serial-to-parallel stage
//   pop           in   1  consumer read request
//   clr_err       in   1  synchronous clear of ERROR state and overflow_err
//   out_data      out  8  registered read data
//   out_valid     out  1  out_data valid this cycle
//   fifo_full     out  1  count == DEPTH
//   fifo_empty    out  1  count == 0
//   almost_full   out  1  see AF_THRESH
//   almost_empty  out  1  see AE_THRESH
//   overflow_err  out  1  sticky; a push was lost
//   link_state    out  2  0=IDLE 1=ACTIVE 2=ERROR
// BEHAVIOUR
// - Reset (reset_L=0, async): pointers and count = 0; out_data=8'h00; out_valid=0; overflow_err=0;
//   link_state=IDLE; fifo_empty=1, almost_empty=1, others 0.
// - Push request = in_word[8]==1 && link_state!=ERROR. Words with valid=0 are discarded, never stored.
// - Push accepted if count<DEPTH, or if count==DEPTH and an effective pop occurs the same cycle.
// - Push request while full without pop -> word lost; overflow_err<=1; link_state<=ERROR.
// - Effective pop = pop && count>0. Next cycle: out_data=head entry, out_valid=1 (latency 1).
// - pop while empty is ignored: out_valid=0 next cycle, out_data holds last value.
// - No bypass: push+pop on an empty FIFO stores the word; pop is ignored.
// - count updates +1 / -1 / 0 for push-only / pop-only / both or neither. Pointers wrap modulo DEPTH.
// - Flags are combinational from the registered count.
// - FSM transitions:
//     IDLE   -> ACTIVE  on the first accepted push
//     ACTIVE -> IDLE    after 16 consecutive cycles with in_word[8]=0 and FIFO empty
//     any    -> ERROR   on overflow (priority over other transitions)
//     ERROR  -> IDLE    on clr_err
// - In ERROR: pushes are blocked, pops continue, so the consumer can drain the FIFO.
// - clr_err clears overflow_err in the same edge as the state change. clr_err in non-ERROR states
//   has no effect.
// - Reset asserted mid-operation discards all contents immediately.
// CONFIGURATION
//   COM_FILTER_EN defined:
//     - Words with valid=1 and data==COM (8'hBC) are also dropped.
//     - These words do not count as activity for the IDLE timeout.
//   COM_FILTER_EN undefined:
//     - Only in_word[8] gates the push; 8'hBC with valid=1 is stored as ordinary data.
// STRUCTURE
//   Package sp_rx_pkg:
//     - COM_CHAR = 8'hBC
//     - link_state encodings (LS_IDLE, LS_ACTIVE, LS_ERROR)
//     - IDLE_TIMEOUT = 16
//   Sub-module rx_fifo_mem: DEPTH x 8 register array, write port (we, waddr, wdata) and registered
//   read port. Pointers, count, flags and FSM live in sp_rx_buffer.
// TESTING
// 1. Reset then 3 valid words A1,B2,C3 (in_word=9'h1A1...), then pop x3
//    -> out_data A1,B2,C3 one cycle after each pop; link_state 0->1.
// 2. Valid words interleaved with 9'h0BC idles -> only valid bytes stored; count matches valid words.
// 3. Fill to 8, push a 9th without pop -> overflow_err=1, link_state=2, 9th byte lost.
//    Drain -> the 8 original bytes come out; clr_err -> link_state=0.
// 4. Full plus push and pop in the same cycle -> count stays 8, no overflow, order preserved.
//    Empty plus push and pop -> out_valid=0, count=1.
// 5. Flag sweep 0..8 entries -> almost_empty at count<=2, almost_full at count>=6.
//    Drop reset_L mid-burst -> all outputs at reset values asynchronously.
// 6. COM_FILTER_EN on: input 9'h1BC -> not stored. Off: the same input -> stored, out_data=8'hBC.
//    16 idle cycles when empty -> link_state ACTIVE->IDLE.

Source files
------------

// File: rtl/sp_rx_pkg.sv
// Shared constants and link-state encodings for the receive buffer.
// Optional COM filtering is selected by COM_FILTER_EN (see sp_rx_buffer).
package sp_rx_pkg;

  localparam logic [7:0] COM_CHAR     = 8'hBC;
  localparam int         IDLE_TIMEOUT = 16;

  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,
    LS_ACTIVE = 2'd1,
    LS_ERROR  = 2'd2
  } link_state_e;

  function automatic logic is_com(input logic [7:0] d);
    return d == COM_CHAR;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x 8 storage array with one write port and a registered read port.
// The read register resets to zero; the array itself is not reset.
module rx_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read sees the pre-write value when both ports hit the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_rdata <= 8'h00;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sp_rx_buffer.sv
// Receive elastic buffer: drops idle words, FIFOs valid bytes, tracks link state.
// Define COM_FILTER_EN to also drop valid COM (8'hBC) characters.
module sp_rx_buffer
  import sp_rx_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic       clk2f,
  input  logic       reset_L,
  input  logic [8:0] in_word,
  input  logic       pop,
  input  logic       clr_err,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic       overflow_err,
  output logic [1:0] link_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [4:0]    r_idle;
  logic          r_ovf;
  logic          r_valid;
  link_state_e   r_state;
  link_state_e   w_nstate;

  logic w_act;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_ovf;
  logic w_quiet;
  logic w_idle_hit;
  logic w_full;
  logic w_empty;

`ifdef COM_FILTER_EN
  assign w_act = in_word[8] && !is_com(in_word[7:0]);
`else
  assign w_act = in_word[8];
`endif

  assign w_full     = r_count == CW'(DEPTH);
  assign w_empty    = r_count == '0;
  assign w_push_req = w_act && (r_state != LS_ERROR);
  assign w_pop      = pop && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf      = w_push_req && w_full && !w_pop;
  assign w_quiet    = !w_act && w_empty;
  assign w_idle_hit = w_quiet &&
                      (r_idle == 5'(IDLE_TIMEOUT - 1));

  rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk2f),
    .rst_n (reset_L),
    .we    (w_push),
    .waddr (r_wptr),
    .wdata (in_word[7:0]),
    .re    (w_pop),
    .raddr (r_rptr),
    .rdata (out_data)
  );

  always_ff @(posedge clk2f or negedge reset_L) begin
    if (!reset_L) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Counts consecutive quiet cycles while the link is up.
  always_ff @(posedge clk2f or negedge reset_L) begin
    if (!reset_L)
      r_idle <= '0;
    else if (r_state != LS_ACTIVE || !w_quiet)
      r_idle <= '0;
    else if (!w_idle_hit)
      r_idle <= r_idle + 1'b1;
  end

  always_ff @(posedge clk2f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= LS_IDLE;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_ovf)
        r_ovf <= 1'b1;
      else if (r_state == LS_ERROR && clr_err)
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      LS_IDLE: begin
        if (w_ovf)       w_nstate = LS_ERROR;
        else if (w_push) w_nstate = LS_ACTIVE;
      end
      LS_ACTIVE: begin
        if (w_ovf)           w_nstate = LS_ERROR;
        else if (w_idle_hit) w_nstate = LS_IDLE;
      end
      LS_ERROR: begin
        if (clr_err) w_nstate = LS_IDLE;
      end
      default: w_nstate = LS_IDLE;
    endcase
  end

  assign out_valid    = r_valid;
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = r_count >= CW'(AF_THRESH);
  assign almost_empty = r_count <= CW'(AE_THRESH);
  assign overflow_err = r_ovf;
  assign link_state   = r_state;

endmodule

// File: tb/tb_sp_rx_buffer.sv
// Directed self-checking bench for sp_rx_buffer.
// Build with or without COM_FILTER_EN to match the DUT configuration.
module tb_sp_rx_buffer;

  logic       clk2f = 1'b0;
  logic       reset_L;
  logic [8:0] in_word;
  logic       pop;
  logic       clr_err;
  logic [7:0] out_data;
  logic       out_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow_err;
  logic [1:0] link_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk2f = ~clk2f;

  sp_rx_buffer dut (
    .clk2f        (clk2f),
    .reset_L      (reset_L),
    .in_word      (in_word),
    .pop          (pop),
    .clr_err      (clr_err),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow_err (overflow_err),
    .link_state   (link_state)
  );

  // One clock: drive inputs, take the edge, settle 1 time unit.
  task automatic cyc(input logic [8:0] w,
                     input logic p,
                     input logic c);
    in_word = w;
    pop     = p;
    clr_err = c;
    @(posedge clk2f);
    #1;
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    in_word = '0;
    pop     = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk2f);
    #1;
    checks++;
    if ({out_data, out_valid, fifo_full, fifo_empty,
         almost_full, almost_empty, overflow_err, link_state}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset: got d=%h v=%b f=%b e=%b af=%b ae=%b o=%b ls=%0d",
               out_data, out_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow_err, link_state);
    end
    reset_L = 1'b1;
    cyc(9'h000, 0, 0);
  endtask

  task automatic test_basic;
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    cyc(9'h1A1, 0, 0);
    checks++;
    if (link_state !== 2'd1) begin
      failures++;
      $display("FAIL basic_active: got %0d want 1", link_state);
    end
    cyc(9'h1B2, 0, 0);
    cyc(9'h1C3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(9'h000, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        failures++;
        $display("FAIL basic_pop%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, exp[i]);
      end
    end
    cyc(9'h000, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'hC3) begin
      failures++;
      $display("FAIL basic_empty_pop: got v=%b d=%h want v=0 d=c3",
               out_valid, out_data);
    end
  endtask

  task automatic test_interleave;
    logic [8:0] seq [6];
    logic [7:0] exp [3];
    seq[0] = 9'h111; seq[1] = 9'h0BC; seq[2] = 9'h122;
    seq[3] = 9'h0BC; seq[4] = 9'h0BC; seq[5] = 9'h133;
    exp[0] = 8'h11;  exp[1] = 8'h22;  exp[2] = 8'h33;
    for (int i = 0; i < 6; i++) cyc(seq[i], 0, 0);
    checks++;
    if (almost_empty !== 1'b0 || fifo_empty !== 1'b0) begin
      failures++;
      $display("FAIL ilv_count3: got ae=%b e=%b want 0 0",
               almost_empty, fifo_empty);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(9'h000, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        failures++;
        $display("FAIL ilv_pop%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, exp[i]);
      end
    end
    cyc(9'h000, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1) begin
      failures++;
      $display("FAIL ilv_drained: got v=%b e=%b want v=0 e=1",
               out_valid, fifo_empty);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) cyc({1'b1, 8'h40 + 8'(i)}, 0, 0);
    checks++;
    if (fifo_full !== 1'b1 || almost_full !== 1'b1 ||
        overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_full: got f=%b af=%b o=%b want 1 1 0",
               fifo_full, almost_full, overflow_err);
    end
    cyc(9'h199, 0, 0);
    checks++;
    if (overflow_err !== 1'b1 || link_state !== 2'd2) begin
      failures++;
      $display("FAIL ovf_err: got o=%b ls=%0d want o=1 ls=2",
               overflow_err, link_state);
    end
    // Push during ERROR must be blocked while draining continues.
    cyc(9'h177, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h40) begin
      failures++;
      $display("FAIL ovf_drain0: got v=%b d=%h want v=1 d=40",
               out_valid, out_data);
    end
    for (int i = 1; i < 8; i++) begin
      cyc(9'h000, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h40 + 8'(i)) begin
        failures++;
        $display("FAIL ovf_drain%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 8'h40 + 8'(i));
      end
    end
    cyc(9'h000, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1 ||
        link_state !== 2'd2) begin
      failures++;
      $display("FAIL ovf_lost: got v=%b e=%b ls=%0d want 0 1 2",
               out_valid, fifo_empty, link_state);
    end
    cyc(9'h000, 0, 1);
    checks++;
    if (link_state !== 2'd0 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got ls=%0d o=%b want ls=0 o=0",
               link_state, overflow_err);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) cyc({1'b1, 8'h50 + 8'(i)}, 0, 0);
    cyc(9'h158, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h50 ||
        fifo_full !== 1'b1 || overflow_err !== 1'b0 ||
        link_state !== 2'd1) begin
      failures++;
      $display("FAIL b2b_full: got v=%b d=%h f=%b o=%b ls=%0d want 1 50 1 0 1",
               out_valid, out_data, fifo_full, overflow_err, link_state);
    end
    for (int i = 1; i < 9; i++) begin
      cyc(9'h000, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h50 + 8'(i)) begin
        failures++;
        $display("FAIL b2b_order%0d: got v=%b d=%h want v=1 d=%h",
                 i, out_valid, out_data, 8'h50 + 8'(i));
      end
    end
    cyc(9'h1AA, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b0 ||
        almost_empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_empty: got v=%b e=%b ae=%b want 0 0 1",
               out_valid, fifo_empty, almost_empty);
    end
    cyc(9'h000, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      failures++;
      $display("FAIL b2b_nobypass: got v=%b d=%h want v=1 d=aa",
               out_valid, out_data);
    end
  endtask

  task automatic test_flags;
    logic [3:0] exp;
    for (int k = 0; k <= 8; k++) begin
      exp = {k <= 2, k >= 6, k == 0, k == 8};
      checks++;
      if ({almost_empty, almost_full, fifo_empty, fifo_full} !== exp) begin
        failures++;
        $display("FAIL flags_n%0d: got ae/af/e/f=%b want %b", k,
                 {almost_empty, almost_full, fifo_empty, fifo_full}, exp);
      end
      if (k < 8) cyc({1'b1, 8'h60 + 8'(k)}, 0, 0);
    end
    // Asynchronous reset in the middle of a cycle.
    in_word = 9'h170;
    #3;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({out_data, out_valid, fifo_full, fifo_empty,
         almost_full, almost_empty, overflow_err, link_state}
        !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0}) begin
      failures++;
      $display("FAIL async_reset: got d=%h v=%b f=%b e=%b af=%b ae=%b o=%b ls=%0d",
               out_data, out_valid, fifo_full, fifo_empty,
               almost_full, almost_empty, overflow_err, link_state);
    end
    in_word = 9'h000;
    @(posedge clk2f);
    #1;
    reset_L = 1'b1;
    cyc(9'h000, 0, 0);
  endtask

  task automatic test_com;
    cyc(9'h1BC, 0, 0);
    cyc(9'h000, 1, 0);
`ifdef COM_FILTER_EN
    checks++;
    if (out_valid !== 1'b0 || fifo_empty !== 1'b1 ||
        link_state !== 2'd0) begin
      failures++;
      $display("FAIL com_drop: got v=%b e=%b ls=%0d want 0 1 0",
               out_valid, fifo_empty, link_state);
    end
`else
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hBC) begin
      failures++;
      $display("FAIL com_store: got v=%b d=%h want v=1 d=bc",
               out_valid, out_data);
    end
`endif
  endtask

  task automatic test_idle_timeout;
    cyc(9'h101, 0, 0);
    cyc(9'h000, 1, 0);
    checks++;
    if (out_data !== 8'h01 || link_state !== 2'd1) begin
      failures++;
      $display("FAIL idle_setup: got d=%h ls=%0d want d=01 ls=1",
               out_data, link_state);
    end
    repeat (15) cyc(9'h000, 0, 0);
    checks++;
    if (link_state !== 2'd1) begin
      failures++;
      $display("FAIL idle_15: got ls=%0d want 1", link_state);
    end
    cyc(9'h000, 0, 0);
    checks++;
    if (link_state !== 2'd0) begin
      failures++;
      $display("FAIL idle_16: got ls=%0d want 0", link_state);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_overflow();
    test_back_to_back();
    test_flags();
    test_com();
    test_idle_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
